regfile_bank_p: RTL

Parametrised register file for the 8-bit CPU datapath, the next generation of the fixed 16x8 register bank. It provides:
- one write port and three registered read ports with write-first bypass;
- a status register (SREG) with per-bit write mask;
- an optional hard-wired zero register;
- a sequential soft-clear engine with busy/done handshake.

It sits between decode (register addresses) and the ALU/writeback stage.

---
 rtl/regfile_bank_p.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/regfile_bank_p.sv
// regfile_bank_p: DEPTH x DATA_W register file with one write port, three
// registered write-first read ports, a bit-masked status register and a
// sequential soft-clear engine.
module regfile_bank_p #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 4,
  parameter bit          ZERO_R0 = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd1_addr,
  input  logic [ADDR_W-1:0] rd2_addr,
  input  logic [ADDR_W-1:0] rd3_addr,
  output logic [DATA_W-1:0] rd1_data,
  output logic [DATA_W-1:0] rd2_data,
  output logic [DATA_W-1:0] rd3_data,
  input  logic              sreg_we,
  input  logic [DATA_W-1:0] sreg_mask,
  input  logic [DATA_W-1:0] sreg_i,
  output logic [DATA_W-1:0] sreg_o,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic              wr_drop
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_cnt, w_cnt_next;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_sreg;
  logic                r_clr_done;
  logic                r_wr_drop;
  logic [DATA_W-1:0]   r_rd_data [3];

  logic                w_wen;
  logic [ADDR_W-1:0]   w_waddr;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_last;
  logic [ADDR_W-1:0]   w_rd_addr [3];
  logic [DATA_W-1:0]   w_rd_next [3];

  assign w_last       = &r_cnt;
  assign w_rd_addr[0] = rd1_addr;
  assign w_rd_addr[1] = rd2_addr;
  assign w_rd_addr[2] = rd3_addr;

  // Effective write port: the clear engine owns it while sweeping.
  always_comb begin
    w_wen   = wr_en;
    w_waddr = wr_addr;
    w_wdata = wr_data;
    if (r_state == StClear) begin
      w_wen   = 1'b1;
      w_waddr = r_cnt;
      w_wdata = '0;
    end
    // Hard-wired zero register swallows writes to address 0 (no drop pulse).
    if (ZERO_R0 && (w_waddr == '0)) begin
      w_wen = 1'b0;
    end
  end

  // Clear FSM next-state and sweep counter.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (clr_req) begin
          w_state_next = StClear;
          w_cnt_next   = '0;
        end
      end
      StClear: begin
        // Counter wraps to 0 on the final sweep edge.
        w_cnt_next = r_cnt + 1'b1;
        if (w_last) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Write-first read data for each port.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_rd_next[i] = r_mem[w_rd_addr[i]];
      if (ZERO_R0 && (w_rd_addr[i] == '0)) begin
        w_rd_next[i] = '0;
      end else if (w_wen && (w_waddr == w_rd_addr[i])) begin
        w_rd_next[i] = w_wdata;
      end
    end
  end

  // FSM state, counter and handshake pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_clr_done <= 1'b0;
      r_wr_drop  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_clr_done <= (r_state == StClear) && w_last;
      r_wr_drop  <= (r_state == StClear) && wr_en;
    end
  end

  // Register array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wen) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Registered read ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        r_rd_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_rd_data[i] <= w_rd_next[i];
      end
    end
  end

  // Status register with per-bit write mask; untouched by the clear engine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg <= '0;
    end else if (sreg_we) begin
      r_sreg <= (r_sreg & ~sreg_mask) | (sreg_i & sreg_mask);
    end
  end

  assign rd1_data = r_rd_data[0];
  assign rd2_data = r_rd_data[1];
  assign rd3_data = r_rd_data[2];
  assign sreg_o   = r_sreg;
  assign busy     = (r_state == StClear);
  assign clr_done = r_clr_done;
  assign wr_drop  = r_wr_drop;

endmodule
